// File: rtl/channel_interleaver.sv
// rtl/channel_interleaver.sv - bit-serial row-in/column-out block interleaver, single-buffered.
// Define CHINTLV_COL_PERM_EN to bit-reverse the column read order.
module channel_interleaver #(
  parameter int ROWS = 3,
  parameter int COLS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_start,
  output logic in_ready,
  output logic y,
  output logic y_valid,
  output logic out_done
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam int CB = $clog2(COLS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    mem;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   waddr;
  logic [RW-1:0]   rcnt;
  logic [CB-1:0]   ccnt;
  logic [CB-1:0]   pcol;
  logic [CW-1:0]   raddr;
  logic            accept;
  logic            fill_last;
  logic            issue;
  logic            rd_last;

`ifdef CHINTLV_COL_PERM_EN
  function automatic logic [CB-1:0] bit_rev(input logic [CB-1:0] v);
    logic [CB-1:0] r;
    r = '0;
    for (int i = 0; i < CB; i++) r[i] = v[CB-1-i];
    return r;
  endfunction

  assign pcol = bit_rev(ccnt);
`else
  assign pcol = ccnt;
`endif

  assign raddr   = CW'(int'(rcnt) * COLS + int'(pcol));
  assign rd_last = (rcnt == RW'(ROWS - 1)) && (ccnt == CB'(COLS - 1));
  assign waddr   = in_start ? '0 : wcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  // The read of j=0 is issued on the same edge that accepts the last bit,
  // so the first output lands in the cycle right after that accept.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == FILL);
    accept    = 1'b0;
    fill_last = 1'b0;
    issue     = 1'b0;
    case (state)
      FILL: begin
        accept    = in_valid;
        fill_last = in_valid & ~in_start & (wcnt == CW'(N - 1));
        issue     = fill_last;
        if (fill_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        issue = ~out_done;
        if (out_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[waddr] <= in_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt     <= '0;
      rcnt     <= '0;
      ccnt     <= '0;
      y        <= 1'b0;
      y_valid  <= 1'b0;
      out_done <= 1'b0;
    end else begin
      if (accept) begin
        if (in_start)                  wcnt <= CW'(1);
        else if (wcnt == CW'(N - 1))   wcnt <= '0;
        else                           wcnt <= wcnt + CW'(1);
      end
      if (issue) begin
        y        <= mem[raddr];
        y_valid  <= 1'b1;
        out_done <= rd_last;
        // Column wraps naturally at COLS, leaving both counters at 0 for the next frame.
        if (rcnt == RW'(ROWS - 1)) begin
          rcnt <= '0;
          ccnt <= ccnt + CB'(1);
        end else begin
          rcnt <= rcnt + RW'(1);
        end
      end else begin
        y        <= 1'b0;
        y_valid  <= 1'b0;
        out_done <= 1'b0;
      end
    end
  end

endmodule
